// File: rtl/pipe_stage.sv
// One slot of the elastic pipeline: a data register, its valid bit and the
// ready term that lets this slot accept whenever it is empty or draining.
module pipe_stage #(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  // The slot can take a new item if it is empty or its item leaves this edge.
  assign rdy = !valid | dn_ready;

  // Load from upstream when ready, hold on stall, drop everything on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every stage sampling the old
      // neighbour values at the same edge, which is what makes data shift.
      valid <= 1'b0;
      // NOTE: the data register is reset too so dataout is defined out of
      // reset; only the valid bit is functionally needed.
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic register pipeline of DEPTH valid/ready stages with registered
// outputs, bubble collapsing, synchronous flush and an occupancy count.
module elastic_pipeline #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           datain,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           dataout,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  // Per-stage signals kept as unpacked arrays so the ready chain, which runs
  // from the output back to the input, is seen as independent nets.
  logic             rdy      [DEPTH+1];
  logic             valid    [DEPTH];
  logic [WIDTH-1:0] data     [DEPTH];
  logic             st_valid [DEPTH];
  logic [WIDTH-1:0] st_data  [DEPTH];

  logic accept;
  logic deliver;

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] & !flush;
  assign accept     = in_valid & in_ready;
  assign deliver    = out_valid & out_ready;
  assign out_valid  = valid[DEPTH-1];
  assign dataout    = data[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign st_valid[i] = accept;
      assign st_data[i]  = datain;
    end else begin : g_body
      assign st_valid[i] = valid[i-1];
      assign st_data[i]  = data[i-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (st_valid[i]),
      .up_data  (st_data[i]),
      .dn_ready (rdy[i+1]),
      .valid    (valid[i]),
      .data     (data[i]),
      .rdy      (rdy[i])
    );
  end

  // Track occupancy: +1 per accept, -1 per delivery, zero on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({accept, deliver})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
